// File: rtl/mbu_pkg.sv
// Shared definitions for the memory bank unit: boot bank constants,
// operating mode encoding and index width helpers.
package mbu_pkg;

  // Default boot-mode extended addresses (ROM / RAM boot images)
  localparam logic [7:0] MBU_BOOT_ROM = 8'h00;
  localparam logic [7:0] MBU_BOOT_RAM = 8'h80;

  typedef enum logic {
    MODE_BOOT   = 1'b0,
    MODE_NORMAL = 1'b1
  } mbu_mode_e;

  // Bank select width; never narrower than one bit
  function automatic int unsigned sel_width(input int unsigned banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  // Context register width; never narrower than one bit
  function automatic int unsigned ctx_width(input int unsigned ctxs);
    return (ctxs > 1) ? $clog2(ctxs) : 1;
  endfunction

endpackage

// File: rtl/mbu_regfile.sv
// Bank register file: one synchronous write port and two registered read
// ports. Both read ports forward same-cycle write data on an index match.
// Port A can alternatively load a substitute value (used for boot mode).
module mbu_regfile
  import mbu_pkg::*;
#(
  parameter int unsigned AW = 3,
  parameter int unsigned W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re_a,
  input  logic          alt_a,
  input  logic [W-1:0]  alt_data_a,
  input  logic [AW-1:0] raddr_a,
  output logic [W-1:0]  q_a,
  input  logic          re_b,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  q_b
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];

  // Storage behaves like SRAM: written on the clock, never reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Port A: substitute value, forwarded write data, or stored entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a <= '0;
    end else if (re_a) begin
      if (alt_a)                        q_a <= alt_data_a;
      else if (we && waddr == raddr_a)  q_a <= wdata;
      else                              q_a <= mem[raddr_a];
    end
  end

  // Port B: forwarded write data or stored entry; holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_b <= '0;
    end else if (re_b) begin
      if (we && waddr == raddr_b) q_b <= wdata;
      else                        q_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/mbu_banked.sv
// Memory bank unit: supplies the extended address for each memory cycle and
// gives microcode read/write access to the bank registers.
// Optional feature macro: MBU_BANKED_CTX_EN (per-context bank replication).
module mbu_banked
  import mbu_pkg::*;
#(
  parameter int unsigned       BANKS    = 8,
  parameter int unsigned       BANK_W   = 8,
  parameter int unsigned       CTXS     = 4,
  parameter logic [BANK_W-1:0] BOOT_ROM = BANK_W'(MBU_BOOT_ROM),
  parameter logic [BANK_W-1:0] BOOT_RAM = BANK_W'(MBU_BOOT_RAM),
  localparam int unsigned      SELW     = sel_width(BANKS),
  localparam int unsigned      CTXW     = ctx_width(CTXS)
) (
  input  logic              clk4,
  input  logic              nrsthold,
  input  logic              nfpram_rom,
  input  logic              nmem,
  input  logic [SELW-1:0]   sel,
  input  logic              nwr_mb,
  input  logic [SELW-1:0]   wsel,
  input  logic [BANK_W-1:0] din,
  input  logic              nrd_mb,
  input  logic [SELW-1:0]   rsel,
  input  logic              nwr_ctx,
  input  logic [CTXW-1:0]   ctx_in,
  output logic [BANK_W-1:0] aext,
  output logic [BANK_W-1:0] dout,
  output logic              dout_valid,
  output logic              nwar,
  output logic              boot,
  output logic [CTXW-1:0]   ctx
);

`ifdef MBU_BANKED_CTX_EN
  localparam int unsigned AW = SELW + CTXW;

  logic [CTXW-1:0] ctx_q;

  // Context register; accesses in the loading cycle still see the old value
  always_ff @(posedge clk4 or negedge nrsthold) begin
    if (!nrsthold)     ctx_q <= '0;
    else if (!nwr_ctx) ctx_q <= ctx_in;
  end

  assign ctx = ctx_q;

  logic [AW-1:0] waddr, aaddr, raddr;
  assign waddr = {ctx_q, wsel};
  assign aaddr = {ctx_q, sel};
  assign raddr = {ctx_q, rsel};
`else
  localparam int unsigned AW = SELW;

  logic ctx_in_unused;
  assign ctx_in_unused = ^ctx_in;
  assign ctx = '0;

  logic [AW-1:0] waddr, aaddr, raddr;
  assign waddr = wsel;
  assign aaddr = sel;
  assign raddr = rsel;
`endif

  mbu_mode_e mode_q;
  logic      nwar_q;
  logic      dout_valid_q;

  // Boot mode persists until the first bank or context write
  always_ff @(posedge clk4 or negedge nrsthold) begin
    if (!nrsthold) begin
      mode_q       <= MODE_BOOT;
      nwar_q       <= 1'b1;
      dout_valid_q <= 1'b0;
    end else begin
      nwar_q       <= nwr_mb;
      dout_valid_q <= !nrd_mb;
      if (!nwr_mb || !nwr_ctx) mode_q <= MODE_NORMAL;
    end
  end

  assign boot       = (mode_q == MODE_BOOT);
  assign nwar       = nwar_q;
  assign dout_valid = dout_valid_q;

  mbu_regfile #(
    .AW (AW),
    .W  (BANK_W)
  ) u_regfile (
    .clk        (clk4),
    .rst_n      (nrsthold),
    .we         (!nwr_mb),
    .waddr      (waddr),
    .wdata      (din),
    .re_a       (!nmem),
    .alt_a      (mode_q == MODE_BOOT),
    .alt_data_a (nfpram_rom ? BOOT_RAM : BOOT_ROM),
    .raddr_a    (aaddr),
    .q_a        (aext),
    .re_b       (!nrd_mb),
    .raddr_b    (raddr),
    .q_b        (dout)
  );

endmodule

// File: tb/tb_mbu_banked.sv
// Scoreboard bench for mbu_banked: a driver applies stimulus on the falling
// edge and pushes the reference model's expected outputs; a monitor pops and
// compares them shortly after each rising edge.
module tb_mbu_banked;

`ifdef MBU_BANKED_CTX_EN
  localparam bit CTX_EN = 1'b1;
`else
  localparam bit CTX_EN = 1'b0;
`endif

  logic       clk4 = 1'b0;
  logic       nrsthold = 1'b1;
  logic       nfpram_rom = 1'b0;
  logic       nmem = 1'b1;
  logic [2:0] sel = '0;
  logic       nwr_mb = 1'b1;
  logic [2:0] wsel = '0;
  logic [7:0] din = '0;
  logic       nrd_mb = 1'b1;
  logic [2:0] rsel = '0;
  logic       nwr_ctx = 1'b1;
  logic [1:0] ctx_in = '0;
  logic [7:0] aext, dout;
  logic       dout_valid, nwar, boot;
  logic [1:0] ctx;

  mbu_banked #(
    .BANKS    (8),
    .BANK_W   (8),
    .CTXS     (4),
    .BOOT_ROM (8'h00),
    .BOOT_RAM (8'h80)
  ) dut (
    .clk4       (clk4),
    .nrsthold   (nrsthold),
    .nfpram_rom (nfpram_rom),
    .nmem       (nmem),
    .sel        (sel),
    .nwr_mb     (nwr_mb),
    .wsel       (wsel),
    .din        (din),
    .nrd_mb     (nrd_mb),
    .rsel       (rsel),
    .nwr_ctx    (nwr_ctx),
    .ctx_in     (ctx_in),
    .aext       (aext),
    .dout       (dout),
    .dout_valid (dout_valid),
    .nwar       (nwar),
    .boot       (boot),
    .ctx        (ctx)
  );

  always #5 clk4 = ~clk4;

  typedef struct {
    logic       rom;
    logic       nmem;
    logic [2:0] sel;
    logic       nwr;
    logic [2:0] wsel;
    logic [7:0] din;
    logic       nrd;
    logic [2:0] rsel;
    logic       nwc;
    logic [1:0] ctxin;
  } stim_t;

  typedef struct {
    logic [7:0] aext;
    logic [7:0] dout;
    logic       dv;
    logic       nwar;
    logic       boot;
    logic [1:0] ctx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic rom_mode = 1'b0;

  // Reference model state: bank contents survive reset like SRAM
  logic [7:0] mmem [4][8];
  logic [7:0] m_aext, m_dout;
  logic       m_boot;
  logic [1:0] m_ctx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t mk(input logic nm, input logic [2:0] s, input logic nw,
                               input logic [2:0] ws, input logic [7:0] d, input logic nr,
                               input logic [2:0] rs, input logic nc, input logic [1:0] ci);
    stim_t t;
    t.rom = rom_mode; t.nmem = nm; t.sel = s; t.nwr = nw; t.wsel = ws; t.din = d;
    t.nrd = nr; t.rsel = rs; t.nwc = nc; t.ctxin = ci;
    return t;
  endfunction

  // Apply the write first; reads then see the updated array, which is what
  // write-through and same-index read forwarding amount to.
  task automatic model_step(input stim_t s);
    exp_t e;
    if (!s.nwr) mmem[m_ctx][s.wsel] = s.din;
    if (!s.nmem) m_aext = m_boot ? (s.rom ? 8'h80 : 8'h00) : mmem[m_ctx][s.sel];
    if (!s.nrd) m_dout = mmem[m_ctx][s.rsel];
    if (CTX_EN && !s.nwc) m_ctx = s.ctxin;
    if (!s.nwr || !s.nwc) m_boot = 1'b0;
    e.aext = m_aext; e.dout = m_dout; e.dv = !s.nrd; e.nwar = s.nwr;
    e.boot = m_boot; e.ctx = m_ctx;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input stim_t s);
    @(negedge clk4);
    nfpram_rom = s.rom; nmem = s.nmem; sel = s.sel; nwr_mb = s.nwr; wsel = s.wsel;
    din = s.din; nrd_mb = s.nrd; rsel = s.rsel; nwr_ctx = s.nwc; ctx_in = s.ctxin;
    model_step(s);
  endtask

  task automatic idle();
    cyc(mk(1, 0, 1, 0, 8'h00, 1, 0, 1, 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_aext"}, aext, 8'h00);
    chk({tag, "_dout"}, dout, 8'h00);
    chk({tag, "_dout_valid"}, dout_valid, 1'b0);
    chk({tag, "_nwar"}, nwar, 1'b1);
    chk({tag, "_boot"}, boot, 1'b1);
    chk({tag, "_ctx"}, ctx, 2'd0);
  endtask

  task automatic do_reset();
    @(negedge clk4);
    nmem = 1'b1; nwr_mb = 1'b1; nrd_mb = 1'b1; nwr_ctx = 1'b1;
    #1 nrsthold = 1'b0;
    #1 check_reset_outputs("midreset");
    m_aext = 8'h00; m_dout = 8'h00; m_boot = 1'b1; m_ctx = 2'd0;
    @(negedge clk4);
    nrsthold = 1'b1;
  endtask

  // Monitor: compare one expected record per rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk4);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("aext", aext, e.aext);
        chk("dout", dout, e.dout);
        chk("dout_valid", dout_valid, e.dv);
        chk("nwar", nwar, e.nwar);
        chk("boot", boot, e.boot);
        chk("ctx", ctx, e.ctx);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    stim_t s;
    m_aext = '0; m_dout = '0; m_boot = 1'b1; m_ctx = '0;
    for (int c = 0; c < 4; c++)
      for (int b = 0; b < 8; b++) mmem[c][b] = '0;

    #2 nrsthold = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge clk4);
    nrsthold = 1'b1;

    // Boot-mode address from ROM, then RAM
    cyc(mk(0, 3, 1, 0, 8'h00, 1, 0, 1, 0));
    idle();
    rom_mode = 1'b1;
    cyc(mk(0, 3, 1, 0, 8'h00, 1, 0, 1, 0));
    idle();

    // Preload index 5, then reset: storage must survive
    cyc(mk(1, 0, 0, 5, 8'h3C, 1, 0, 1, 0));
    idle();
    do_reset();

    // Read in boot mode stays in boot mode
    cyc(mk(1, 0, 1, 0, 8'h00, 0, 5, 1, 0));
    idle();
    idle();

    // First write leaves boot mode; then a memory cycle uses the bank
    cyc(mk(1, 0, 0, 2, 8'h12, 1, 0, 1, 0));
    idle();
    cyc(mk(0, 2, 1, 0, 8'h00, 1, 0, 1, 0));
    idle();

    // Write-through to both read ports in the same cycle
    cyc(mk(0, 6, 0, 6, 8'h55, 0, 6, 1, 0));
    idle();

    // Context banking and old-context use during a context load
    cyc(mk(1, 0, 1, 0, 8'h00, 1, 0, 0, 0));
    cyc(mk(1, 0, 0, 1, 8'hA1, 1, 0, 1, 0));
    cyc(mk(1, 0, 1, 0, 8'h00, 1, 0, 0, 1));
    cyc(mk(1, 0, 0, 1, 8'hB1, 1, 0, 1, 0));
    cyc(mk(0, 1, 1, 0, 8'h00, 1, 0, 1, 0));
    cyc(mk(0, 1, 1, 0, 8'h00, 0, 1, 0, 0));
    cyc(mk(0, 1, 1, 0, 8'h00, 0, 1, 1, 0));
    idle();

    // Initialise every bank in every context before random traffic
    for (int c = 0; c < 4; c++) begin
      cyc(mk(1, 0, 1, 0, 8'h00, 1, 0, 0, 2'(c)));
      for (int b = 0; b < 8; b++)
        cyc(mk(1, 0, 0, 3'(b), 8'($urandom), 1, 0, 1, 0));
    end

    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      rom_mode = 1'($urandom_range(0, 1));
      s = mk(($urandom_range(0, 1) == 0), 3'($urandom), ($urandom_range(0, 9) >= 3),
             3'($urandom), 8'($urandom), ($urandom_range(0, 9) >= 4), 3'($urandom),
             ($urandom_range(0, 9) != 0), 2'($urandom));
      // Keep boot mode around for a while after the mid-run reset
      if (i >= 300 && i < 310) begin s.nwr = 1'b1; s.nwc = 1'b1; end
      cyc(s);
    end
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending records", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
